// File: rtl/midi_message_parser_pkg.sv
// Shared MIDI types: channel-voice message record, status-byte constants and
// the data-byte count lookup used by the parser.
package midi_message_parser_pkg;

  typedef enum logic [3:0] {
    NOTE_OFF         = 4'h8,
    NOTE_ON          = 4'h9,
    POLY_PRESSURE    = 4'hA,
    CONTROL_CHANGE   = 4'hB,
    PROGRAM_CHANGE   = 4'hC,
    CHANNEL_PRESSURE = 4'hD,
    PITCH_BEND       = 4'hE
  } message_type_t;

  typedef struct packed {
    message_type_t message_type;
    logic [3:0]    channel;
    logic [6:0]    data_byte1;
    logic [6:0]    data_byte2;
  } message_t;

  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  function automatic logic [1:0] data_bytes_for(input message_type_t t);
    return (t == PROGRAM_CHANGE || t == CHANNEL_PRESSURE) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_message_parser.sv
// Assembles channel-voice messages from a raw MIDI byte stream with running
// status, real-time pass-over, SysEx skipping and an optional channel filter.
module midi_message_parser
  import midi_message_parser_pkg::*;
#(
  parameter int CHANNEL_FILTER = 16,
  parameter bit VEL0_IS_OFF    = 1'b1
) (
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic [7:0] byte_in,
  input  logic       byte_ready,
  output message_t   message,
  output logic       message_ready
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  state_t        state_q, state_d;
  logic          rs_valid_q, rs_valid_d;
  message_type_t rs_type_q, rs_type_d;
  logic [3:0]    rs_chan_q, rs_chan_d;
  logic [6:0]    d1_q, d1_d;
  message_t      msg_q, msg_d;
  logic          rdy_q, rdy_d;

  logic is_data, is_chan, is_rt, is_sys;
  always_comb begin
    is_data = ~byte_in[7];
    is_rt   = (byte_in >= REALTIME_MIN);
    is_sys  = (byte_in[7:4] == 4'hF) && !is_rt;
    is_chan = byte_in[7] && (byte_in[7:4] != 4'hF);
  end

  logic       emit;
  logic [6:0] emit_d1, emit_d2;
  logic       chan_ok;

  assign chan_ok = (CHANNEL_FILTER == 16) || (32'(rs_chan_q) == CHANNEL_FILTER);

  always_comb begin
    state_d    = state_q;
    rs_valid_d = rs_valid_q;
    rs_type_d  = rs_type_q;
    rs_chan_d  = rs_chan_q;
    d1_d       = d1_q;
    emit       = 1'b0;
    emit_d1    = '0;
    emit_d2    = '0;
    if (byte_ready) begin
      if (is_data) begin
        unique case (state_q)
          WAIT_D1: if (rs_valid_q) begin
            if (data_bytes_for(rs_type_q) == 2'd1) begin
              emit    = 1'b1;
              emit_d1 = byte_in[6:0];
            end else begin
              d1_d    = byte_in[6:0];
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit    = 1'b1;
            emit_d1 = d1_q;
            emit_d2 = byte_in[6:0];
            state_d = WAIT_D1;
          end
          default: ;
        endcase
      end else if (is_chan) begin
        rs_valid_d = 1'b1;
        rs_type_d  = message_type_t'(byte_in[7:4]);
        rs_chan_d  = byte_in[3:0];
        state_d    = WAIT_D1;
      end else if (is_sys) begin
        // SysEx end only closes the skip; other system bytes kill running status
        if (byte_in == SYSEX_START) begin
          rs_valid_d = 1'b0;
          state_d    = SYSEX;
        end else if (byte_in == SYSEX_END) begin
          state_d    = IDLE;
        end else begin
          rs_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
    end
  end

  always_comb begin
    msg_d = msg_q;
    rdy_d = 1'b0;
    if (emit && chan_ok) begin
      rdy_d            = 1'b1;
      msg_d.channel    = rs_chan_q;
      msg_d.data_byte1 = emit_d1;
      msg_d.data_byte2 = emit_d2;
      msg_d.message_type = (VEL0_IS_OFF && rs_type_q == NOTE_ON && emit_d2 == 7'd0)
                           ? NOTE_OFF : rs_type_q;
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= IDLE;
      rs_valid_q <= 1'b0;
      rs_type_q  <= NOTE_OFF;
      rs_chan_q  <= '0;
      d1_q       <= '0;
      msg_q      <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_valid_q <= rs_valid_d;
      rs_type_q  <= rs_type_d;
      rs_chan_q  <= rs_chan_d;
      d1_q       <= d1_d;
      msg_q      <= msg_d;
      rdy_q      <= rdy_d;
    end
  end

  assign message       = msg_q;
  assign message_ready = rdy_q;

endmodule

// File: tb/tb_midi_message_parser.sv
// Drives two parser configurations (omni/vel0-off, channel 2/raw) with table,
// hand-written and random byte streams against a queue-based stream model.
module tb_midi_message_parser;
  import midi_message_parser_pkg::*;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic [7:0] byte_in = '0;
  logic       byte_ready = 1'b0;
  message_t   msg_a, msg_b;
  logic       rdy_a, rdy_b;

  always #10 clk = ~clk;

  midi_message_parser #(.CHANNEL_FILTER(16), .VEL0_IS_OFF(1'b1)) dut (
    .clock_50_000_000(clk), .reset_l(reset_l), .byte_in(byte_in),
    .byte_ready(byte_ready), .message(msg_a), .message_ready(rdy_a));

  midi_message_parser #(.CHANNEL_FILTER(2), .VEL0_IS_OFF(1'b0)) dut_f (
    .clock_50_000_000(clk), .reset_l(reset_l), .byte_in(byte_in),
    .byte_ready(byte_ready), .message(msg_b), .message_ready(rdy_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] mk(input logic [3:0] t, input logic [3:0] c,
                                     input logic [6:0] d1, input logic [6:0] d2);
    return {t, c, d1, d2};
  endfunction

  // Stream model: current status byte (0 = none) plus collected data bytes.
  int          st = 0;
  logic [6:0]  dq[$];
  logic [21:0] exp_a = '0, exp_b = '0;
  logic        exp_ra = 1'b0, exp_rb = 1'b0;
  int          pulses_a, pulses_b;

  function automatic int needed(input int s);
    return ((s >> 4) == 'hC || (s >> 4) == 'hD) ? 1 : 2;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [3:0] t, c;
    logic [6:0] d1, d2;
    exp_ra = 1'b0;
    exp_rb = 1'b0;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin st = 0; dq.delete(); return; end
    if (b >= 8'h80) begin st = int'(b); dq.delete(); return; end
    if (st == 0) return;
    dq.push_back(b[6:0]);
    if (dq.size() < needed(st)) return;
    t  = st[7:4];
    c  = st[3:0];
    d1 = dq[0];
    d2 = (needed(st) == 2) ? dq[1] : 7'd0;
    dq.delete();
    exp_ra = 1'b1;
    exp_a  = mk((t == 4'h9 && d2 == 0) ? 4'h8 : t, c, d1, d2);
    if (c == 4'd2) begin
      exp_rb = 1'b1;
      exp_b  = mk(t, c, d1, d2);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    @(negedge clk);
    byte_in    = b;
    byte_ready = rdy;
    if (rdy) model_byte(b);
    else begin exp_ra = 1'b0; exp_rb = 1'b0; end
    @(posedge clk);
    #1;
    chk("rdy_a", 32'(rdy_a), 32'(exp_ra));
    chk("msg_a", 32'(msg_a), 32'(exp_a));
    chk("rdy_b", 32'(rdy_b), 32'(exp_rb));
    chk("msg_b", 32'(msg_b), 32'(exp_b));
    if (rdy_a) pulses_a++;
    if (rdy_b) pulses_b++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    byte_ready = 1'b0;
    reset_l    = 1'b0;
    #2;
    chk("reset_msg_a", 32'(msg_a), 0);
    chk("reset_rdy_a", 32'(rdy_a), 0);
    chk("reset_msg_b", 32'(msg_b), 0);
    st = 0; dq.delete();
    exp_a = '0; exp_b = '0; exp_ra = 1'b0; exp_rb = 1'b0;
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  typedef struct {
    logic [63:0] seq;
    int          n;
    int          pulses;
    int          f_pulses;
    logic [21:0] last;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{64'h903C64,       3, 1, 0, mk(4'h9, 4'h0, 7'h3C, 7'h64)};
    vecs[1] = '{64'h913C644000,   5, 2, 0, mk(4'h8, 4'h1, 7'h40, 7'h00)};
    vecs[2] = '{64'h90F83CFE64,   5, 1, 0, mk(4'h9, 4'h0, 7'h3C, 7'h64)};
    vecs[3] = '{64'hF07E01F8F73C64, 7, 0, 0, 22'h0};
    vecs[4] = '{64'hC50705,       3, 2, 0, mk(4'hC, 4'h5, 7'h05, 7'h00)};
    vecs[5] = '{64'h903CB0077F,   5, 1, 0, mk(4'hB, 4'h0, 7'h07, 7'h7F)};
    vecs[6] = '{64'hE30040F21020, 6, 1, 0, mk(4'hE, 4'h3, 7'h00, 7'h40)};
    vecs[7] = '{64'hD210F811,     4, 2, 2, mk(4'hD, 4'h2, 7'h11, 7'h00)};
    vecs[8] = '{64'h923C00,       3, 1, 1, mk(4'h8, 4'h2, 7'h3C, 7'h00)};
    vecs[9] = '{64'h933C64,       3, 1, 0, mk(4'h9, 4'h3, 7'h3C, 7'h64)};

    do_reset();
    for (int v = 0; v < 10; v++) begin
      do_reset();
      pulses_a = 0;
      pulses_b = 0;
      for (int i = 0; i < vecs[v].n; i++)
        send(8'(vecs[v].seq >> (8 * (vecs[v].n - 1 - i))), 1'b1);
      send(8'h00, 1'b0);
      chk($sformatf("vec%0d_pulses", v), 32'(pulses_a), 32'(vecs[v].pulses));
      chk($sformatf("vec%0d_f_pulses", v), 32'(pulses_b), 32'(vecs[v].f_pulses));
      chk($sformatf("vec%0d_last", v), 32'(msg_a), 32'(vecs[v].last));
    end

    // Gaps between strobes must not disturb a partial message.
    do_reset();
    pulses_a = 0;
    send(8'h92, 1'b1); send(8'h00, 1'b0); send(8'h11, 1'b1);
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h22, 1'b1);
    chk("gap_pulses", 32'(pulses_a), 1);
    chk("gap_msg", 32'(msg_a), 32'(mk(4'h9, 4'h2, 7'h11, 7'h22)));

    // Reset in the middle of a message: trailing data byte must be dropped.
    do_reset();
    pulses_a = 0;
    send(8'h90, 1'b1); send(8'h3C, 1'b1);
    do_reset();
    send(8'h64, 1'b1); send(8'h00, 1'b0);
    chk("rst_mid_pulses", 32'(pulses_a), 0);
    chk("rst_mid_msg", 32'(msg_a), 0);

    // Random stream weighted toward data and channel-status bytes.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(99));
      if (r < 45)      b = 8'($urandom_range(8'h7F));
      else if (r < 75) b = 8'($urandom_range(8'hEF, 8'h80));
      else if (r < 87) b = 8'($urandom_range(8'hFF, 8'hF8));
      else             b = 8'($urandom_range(8'hF7, 8'hF0));
      send(b, ($urandom_range(9) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
